// File: rtl/sb_param_cfg_pkg.sv
// Shared types and sizing helpers for the parametrised switch block and its
// configuration chain.
package sb_param_pkg;

    // Load progress of the shadow chain, derived from the shift counter
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2,
        OVER    = 2'd3
    } cfg_state_e;

    // Chain length: every select field plus one even-parity bit
    function automatic int unsigned chain_len(input int unsigned num_out,
                                              input int unsigned sel_w);
        return num_out * sel_w + 1;
    endfunction

    // Counter must reach LEN+1 (the saturating OVER marker)
    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(len + 2);
    endfunction

endpackage

// File: rtl/sb_param_cfg_if.sv
// Configuration-chain and routing signals of the switch block.
// master = configuration/routing driver, slave = the switch block.
interface sb_param_cfg_if #(
    parameter int unsigned NUM_IN  = 6,
    parameter int unsigned NUM_OUT = 9
);
    logic               ccff_head;
    logic               ccff_en;
    logic               cfg_commit;
    logic               cfg_readback;
    logic               ccff_tail;
    logic               cfg_valid;
    logic               cfg_err;
    logic [NUM_IN-1:0]  in;
    logic [NUM_OUT-1:0] out;

    modport master (
        output ccff_head, ccff_en, cfg_commit, cfg_readback, in,
        input  ccff_tail, cfg_valid, cfg_err, out
    );

    modport slave (
        input  ccff_head, ccff_en, cfg_commit, cfg_readback, in,
        output ccff_tail, cfg_valid, cfg_err, out
    );
endinterface

// File: rtl/sb_cfg_chain.sv
// Double-buffered configuration chain: serial shadow register, load counter
// and state, parity-checked atomic commit into the active register, and
// readback of the active configuration into the shadow register.
module sb_cfg_chain
    import sb_param_pkg::*;
#(
    parameter int unsigned NUM_OUT = 9,
    parameter int unsigned SEL_W   = 3
) (
    input  logic                     prog_clk,
    input  logic                     prog_reset_n,
    input  logic                     i_head,
    input  logic                     i_en,
    input  logic                     i_commit,
    input  logic                     i_readback,
    output logic                     o_tail,
    output logic                     o_valid,
    output logic                     o_err,
    output logic [NUM_OUT*SEL_W-1:0] o_active
);

    localparam int unsigned LEN = chain_len(NUM_OUT, SEL_W);
    localparam int unsigned CW  = cnt_width(LEN);
    localparam int unsigned AW  = NUM_OUT * SEL_W;

    localparam logic [CW-1:0] CNT_FULL = CW'(LEN);
    localparam logic [CW-1:0] CNT_OVER = CW'(LEN + 1);

    logic [LEN-1:0] r_shadow;
    logic [AW-1:0]  r_active;
    logic [CW-1:0]  r_cnt;
    cfg_state_e     r_state;
    logic           r_valid;
    logic           r_err;

    logic           w_par_ok;
    logic [CW-1:0]  w_cnt_inc;
    cfg_state_e     w_state_inc;

    assign w_par_ok = ~(^r_shadow);

    // Next counter value and state for an enabled shift (saturates at LEN+1)
    always_comb begin
        w_cnt_inc   = r_cnt;
        w_state_inc = r_state;
        if (r_cnt != CNT_OVER) begin
            w_cnt_inc = r_cnt + 1'b1;
        end
        if (w_cnt_inc < CNT_FULL) begin
            w_state_inc = LOADING;
        end else if (w_cnt_inc == CNT_FULL) begin
            w_state_inc = FULL;
        end else begin
            w_state_inc = OVER;
        end
    end

    // Chain FSM: commit beats readback beats shift; commit/readback never shift
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_state  <= EMPTY;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else if (i_commit) begin
            if ((r_state == FULL) && w_par_ok) begin
                r_active <= r_shadow[AW-1:0];
                r_valid  <= 1'b1;
                r_err    <= 1'b0;
            end else begin
                r_err    <= 1'b1;
            end
            r_cnt   <= '0;
            r_state <= EMPTY;
        end else if (i_readback) begin
            // Parity bit regenerated so the reloaded stream passes its own check
            r_shadow <= {^r_active, r_active};
            r_cnt    <= CNT_FULL;
            r_state  <= FULL;
            r_err    <= 1'b0;
        end else if (i_en) begin
            r_shadow <= {r_shadow[LEN-2:0], i_head};
            r_cnt    <= w_cnt_inc;
            r_state  <= w_state_inc;
        end
    end

    assign o_tail   = r_shadow[LEN-1];
    assign o_valid  = r_valid;
    assign o_err    = r_err;
    assign o_active = r_active;

endmodule

// File: rtl/sb_param_cfg.sv
// Parametrised switch block: NUM_OUT outputs, each selecting one of NUM_IN
// inputs from the committed configuration held in sb_cfg_chain.
module sb_param_cfg
    import sb_param_pkg::*;
#(
    parameter int unsigned NUM_IN  = 6,
    parameter int unsigned NUM_OUT = 9,
    parameter int unsigned SEL_W   = $clog2(NUM_IN)
) (
    input  logic          prog_clk,
    input  logic          prog_reset_n,
    sb_param_cfg_if.slave bus
);

    localparam int unsigned      AW       = NUM_OUT * SEL_W;
    localparam logic [SEL_W:0]   NUM_IN_V = (SEL_W + 1)'(NUM_IN);

    logic [AW-1:0]      w_active;
    logic               w_tail;
    logic               w_valid;
    logic               w_err;
    logic [NUM_OUT-1:0] w_out;

    sb_cfg_chain #(
        .NUM_OUT (NUM_OUT),
        .SEL_W   (SEL_W)
    ) u_chain (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .i_head       (bus.ccff_head),
        .i_en         (bus.ccff_en),
        .i_commit     (bus.cfg_commit),
        .i_readback   (bus.cfg_readback),
        .o_tail       (w_tail),
        .o_valid      (w_valid),
        .o_err        (w_err),
        .o_active     (w_active)
    );

    // Output j uses the field shifted in (j+1)-th after parity: sel0 sits at the top
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_mux
        logic [SEL_W-1:0] w_sel;
        logic             w_in_range;

        assign w_sel      = w_active[(NUM_OUT - j) * SEL_W - 1 -: SEL_W];
        assign w_in_range = ({1'b0, w_sel} < NUM_IN_V);
        assign w_out[j]   = (w_valid && w_in_range) ? bus.in[w_sel] : 1'b0;
    end

    assign bus.ccff_tail = w_tail;
    assign bus.cfg_valid = w_valid;
    assign bus.cfg_err   = w_err;
    assign bus.out       = w_out;

endmodule

// File: tb/tb_sb_param_cfg.sv
// Directed test of sb_param_cfg with default sizing (NUM_IN=6, NUM_OUT=9, LEN=28).
module tb_sb_param_cfg;

    // Stream A: parity=1, sel0=2, sel1..8=7
    localparam logic [27:0] STREAM_A = 28'b1010_1111_1111_1111_1111_1111_1111;
    // Stream B: parity=0, sels 5,4,3,2,1,0,6,7,0
    localparam logic [27:0] STREAM_B = {1'b0, 27'b101_100_011_010_001_000_110_111_000};
    // Routing of B with in=6'b100101
    localparam logic [8:0]  OUT_B    = 9'b100101001;

    logic prog_clk;
    logic prog_reset_n;
    int unsigned total;
    int unsigned bad;

    sb_param_cfg_if #(.NUM_IN(6), .NUM_OUT(9)) bus ();

    sb_param_cfg #(.NUM_IN(6), .NUM_OUT(9)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .bus          (bus)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic shift_bit(input logic b);
        bus.ccff_en   = 1'b1;
        bus.ccff_head = b;
        @(posedge prog_clk);
        #1;
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
    endtask

    task automatic shift_stream(input logic [27:0] s, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            shift_bit((k < 28) ? s[27 - k] : 1'b0);
        end
    endtask

    task automatic pulse_commit();
        bus.cfg_commit = 1'b1;
        @(posedge prog_clk);
        #1;
        bus.cfg_commit = 1'b0;
    endtask

    task automatic pulse_readback();
        bus.cfg_readback = 1'b1;
        @(posedge prog_clk);
        #1;
        bus.cfg_readback = 1'b0;
    endtask

    task automatic test_reset();
        bus.in = 6'b111111;
        #1;
        total++; if (bus.ccff_tail !== 1'b0) begin bad++; $display("FAIL reset_tail: got %b want 0", bus.ccff_tail); end
        total++; if (bus.cfg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.cfg_valid); end
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.cfg_err); end
        total++; if (bus.out !== 9'd0) begin bad++; $display("FAIL reset_out: got %b want 000000000", bus.out); end
    endtask

    task automatic test_load_commit();
        shift_stream(STREAM_A, 27);
        total++; if (bus.ccff_tail !== 1'b0) begin bad++; $display("FAIL load27_tail: got %b want 0", bus.ccff_tail); end
        shift_bit(STREAM_A[0]);
        total++; if (bus.ccff_tail !== 1'b1) begin bad++; $display("FAIL load28_tail: got %b want 1", bus.ccff_tail); end
        total++; if (bus.cfg_valid !== 1'b0) begin bad++; $display("FAIL precommit_valid: got %b want 0", bus.cfg_valid); end
        pulse_commit();
        total++; if (bus.cfg_valid !== 1'b1) begin bad++; $display("FAIL commit_valid: got %b want 1", bus.cfg_valid); end
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL commit_err: got %b want 0", bus.cfg_err); end
        total++; if (dut.u_chain.r_cnt !== 5'd0) begin bad++; $display("FAIL commit_cnt: got %0d want 0", dut.u_chain.r_cnt); end
        bus.in = 6'b000100;
        #1;
        total++; if (bus.out !== 9'b000000001) begin bad++; $display("FAIL route_a1: got %b want 000000001", bus.out); end
        bus.in = 6'b111011;
        #1;
        total++; if (bus.out !== 9'd0) begin bad++; $display("FAIL route_a2: got %b want 000000000", bus.out); end
    endtask

    task automatic test_short_load();
        shift_stream(STREAM_B, 27);
        pulse_commit();
        bus.in = 6'b000100;
        #1;
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL short_err: got %b want 1", bus.cfg_err); end
        total++; if (bus.cfg_valid !== 1'b1) begin bad++; $display("FAIL short_valid: got %b want 1", bus.cfg_valid); end
        total++; if (bus.out !== 9'b000000001) begin bad++; $display("FAIL short_out: got %b want 000000001", bus.out); end
        total++; if (dut.u_chain.r_cnt !== 5'd0) begin bad++; $display("FAIL short_cnt: got %0d want 0", dut.u_chain.r_cnt); end
    endtask

    task automatic test_over_load();
        shift_stream(STREAM_B, 29);
        pulse_commit();
        bus.in = 6'b000100;
        #1;
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL over_err: got %b want 1", bus.cfg_err); end
        total++; if (bus.out !== 9'b000000001) begin bad++; $display("FAIL over_out: got %b want 000000001", bus.out); end
        shift_stream(STREAM_B, 28);
        pulse_commit();
        bus.in = 6'b100101;
        #1;
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL recover_err: got %b want 0", bus.cfg_err); end
        total++; if (bus.cfg_valid !== 1'b1) begin bad++; $display("FAIL recover_valid: got %b want 1", bus.cfg_valid); end
        total++; if (bus.out !== OUT_B) begin bad++; $display("FAIL route_b: got %b want %b", bus.out, OUT_B); end
    endtask

    task automatic test_bad_parity();
        logic [27:0] s;
        s = STREAM_A ^ 28'h8000000;
        shift_stream(s, 28);
        pulse_commit();
        #1;
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL parity_err: got %b want 1", bus.cfg_err); end
        total++; if (bus.out !== OUT_B) begin bad++; $display("FAIL parity_out: got %b want %b", bus.out, OUT_B); end
        total++; if (dut.u_chain.r_cnt !== 5'd0) begin bad++; $display("FAIL parity_cnt: got %0d want 0", dut.u_chain.r_cnt); end
    endtask

    task automatic test_readback();
        pulse_readback();
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rb_err: got %b want 0", bus.cfg_err); end
        total++; if (dut.u_chain.r_cnt !== 5'd28) begin bad++; $display("FAIL rb_cnt: got %0d want 28", dut.u_chain.r_cnt); end
        for (int unsigned k = 0; k < 28; k++) begin
            total++;
            if (bus.ccff_tail !== STREAM_B[27 - k]) begin
                bad++; $display("FAIL rb_tail[%0d]: got %b want %b", k, bus.ccff_tail, STREAM_B[27 - k]);
            end
            total++;
            if (bus.out !== OUT_B) begin
                bad++; $display("FAIL rb_out[%0d]: got %b want %b", k, bus.out, OUT_B);
            end
            shift_bit(1'b0);
        end
    endtask

    task automatic test_commit_priority();
        // Chain is OVER after the readback drain
        pulse_commit();
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL over_persist_err: got %b want 1", bus.cfg_err); end
        shift_stream(STREAM_B, 28);
        bus.ccff_en   = 1'b1;
        bus.ccff_head = 1'b1;
        pulse_commit();
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
        #1;
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL prio_err: got %b want 0", bus.cfg_err); end
        total++; if (bus.ccff_tail !== 1'b0) begin bad++; $display("FAIL prio_tail: got %b want 0", bus.ccff_tail); end
        total++; if (dut.u_chain.r_shadow !== STREAM_B) begin bad++; $display("FAIL prio_shadow: got %h want %h", dut.u_chain.r_shadow, STREAM_B); end
        total++; if (dut.u_chain.r_cnt !== 5'd0) begin bad++; $display("FAIL prio_cnt: got %0d want 0", dut.u_chain.r_cnt); end
    endtask

    task automatic test_reset_async();
        shift_stream(STREAM_A, 10);
        #2;
        prog_reset_n = 1'b0;
        #1;
        total++; if (bus.cfg_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.cfg_valid); end
        total++; if (bus.out !== 9'd0) begin bad++; $display("FAIL midrst_out: got %b want 000000000", bus.out); end
        total++; if (dut.u_chain.r_shadow !== 28'd0) begin bad++; $display("FAIL midrst_shadow: got %h want 0", dut.u_chain.r_shadow); end
        total++; if (dut.u_chain.r_cnt !== 5'd0) begin bad++; $display("FAIL midrst_cnt: got %0d want 0", dut.u_chain.r_cnt); end
        #2;
        prog_reset_n = 1'b1;
        @(posedge prog_clk);
        #1;
        shift_stream(STREAM_A, 28);
        pulse_commit();
        bus.in = 6'b000100;
        #1;
        total++; if (bus.out !== 9'b000000001) begin bad++; $display("FAIL reload_out: got %b want 000000001", bus.out); end
        #1;
        prog_reset_n = 1'b0;
        #1;
        total++; if (bus.cfg_valid !== 1'b0) begin bad++; $display("FAIL postrst_valid: got %b want 0", bus.cfg_valid); end
        total++; if (bus.ccff_tail !== 1'b0) begin bad++; $display("FAIL postrst_tail: got %b want 0", bus.ccff_tail); end
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL postrst_err: got %b want 0", bus.cfg_err); end
        total++; if (bus.out !== 9'd0) begin bad++; $display("FAIL postrst_out: got %b want 000000000", bus.out); end
        #2;
        prog_reset_n = 1'b1;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        prog_reset_n     = 1'b0;
        bus.ccff_head    = 1'b0;
        bus.ccff_en      = 1'b0;
        bus.cfg_commit   = 1'b0;
        bus.cfg_readback = 1'b0;
        bus.in           = '0;
        #2;
        test_reset();
        #9;
        prog_reset_n = 1'b1;
        @(posedge prog_clk);
        #1;
        test_load_commit();
        test_short_load();
        test_over_load();
        test_bad_parity();
        test_readback();
        test_commit_priority();
        test_reset_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
